// File: rtl/play_ctrl.sv
// play_ctrl: transport-control front end for the music player.
//
// Synchronizes, debounces and one-pulses the raw play, stop and next
// pushbuttons. Runs the STOP/PLAY/PAUSE state machine and produces the step
// tick and the 4-bit playback position. The LED progress chaser consumes
// play_pause as its enable and tick as its step clock.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   btn_play   in   raw play/pause button (async, bouncy, active-high)
//   btn_stop   in   raw stop button
//   btn_next   in   raw skip-forward button
//   play_pause out  registered, 1 exactly while state is PLAY
//   tick       out  registered one-cycle pulse on each position step
//   pos        out  registered playback position 0..15
//   state      out  registered state: STOP=00, PLAY=01, PAUSE=10
//
// Build option: define PLAY_CTRL_AUTOSTOP_EN to make a step that wraps pos
// from 15 to 0 return to STOP instead of looping.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_STOP  | idle, pos and cnt cleared, waiting for play
// ST_PLAY  | step counter running, tick/pos advance every TICK_DIV cycles
// ST_PAUSE | cnt and pos frozen, play resumes from held cnt

module play_ctrl #(
    parameter int DEBOUNCE_LEN = 16,
    parameter int TICK_DIV     = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_play,
    input  logic       btn_stop,
    input  logic       btn_next,
    output logic       play_pause,
    output logic       tick,
    output logic [3:0] pos,
    output logic [1:0] state
);

    localparam int DB_W  = $clog2(DEBOUNCE_LEN);
    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Button bit order in the vectors below: [2]=play, [1]=stop, [0]=next.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_q;
    logic [2:0]      pulse;
    logic [DB_W-1:0] db_cnt [3];

    logic            p_play;
    logic            p_stop;
    logic            p_next;

    state_t          cur_state;
    state_t          nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [3:0]      nxt_pos;
    logic            nxt_tick;
    logic            step_due;

    assign btn_raw = {btn_play, btn_stop, btn_next};
    assign p_play  = pulse[2];
    assign p_stop  = pulse[1];
    assign p_next  = pulse[0];

    // Debounce: the counter only runs while the synchronized level disagrees
    // with the debounced level, so any disagreement shorter than
    // DEBOUNCE_LEN cycles is discarded. Only rising debounced edges pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            pulse <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            pulse <= deb & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_LEN - 1)) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign step_due = (cur_state == ST_PLAY) && (cnt == CNT_W'(TICK_DIV - 1));

    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = cnt;
        nxt_pos   = pos;
        nxt_tick  = 1'b0;
        if (p_stop) begin
            nxt_state = ST_STOP;
            nxt_cnt   = '0;
            nxt_pos   = '0;
        end else begin
            case (cur_state)
                ST_STOP: begin
                    if (p_play) begin
                        nxt_state = ST_PLAY;
                        nxt_cnt   = '0;
                        nxt_pos   = '0;
                    end
                end
                ST_PLAY: begin
                    if (p_play) begin
                        nxt_state = ST_PAUSE;
                    end
                    // A skip absorbs a coincident step; a pause drops it.
                    if (p_next) begin
                        nxt_pos = pos + 4'd1;
                        nxt_cnt = '0;
                    end else if (!p_play) begin
                        if (step_due) begin
                            nxt_cnt  = '0;
                            nxt_pos  = pos + 4'd1;
                            nxt_tick = 1'b1;
`ifdef PLAY_CTRL_AUTOSTOP_EN
                            if (pos == 4'd15) begin
                                nxt_state = ST_STOP;
                                nxt_pos   = '0;
                            end
`endif
                        end else begin
                            nxt_cnt = cnt + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (p_play) begin
                        nxt_state = ST_PLAY;
                    end
                    if (p_next) begin
                        nxt_pos = pos + 4'd1;
                        nxt_cnt = '0;
                    end
                end
                default: begin
                    nxt_state = ST_STOP;
                    nxt_cnt   = '0;
                    nxt_pos   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= ST_STOP;
            cnt        <= '0;
            pos        <= '0;
            tick       <= 1'b0;
            play_pause <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            cnt        <= nxt_cnt;
            pos        <= nxt_pos;
            tick       <= nxt_tick;
            play_pause <= (nxt_state == ST_PLAY);
        end
    end

    assign state = cur_state;

endmodule
